// File: rtl/fx3_packet_scheduler_if.sv
// Handshake and status bundle between the FX3 packet scheduler and its FIFO/GPIF environment.
interface fx3_packet_scheduler_if;
  logic        collectData;
  logic        dataAvailable;
  logic        bufferError;
  logic        fx3Ready;
  logic        readData;
  logic        dataValid;
  logic        endOfPacket;
  logic [15:0] packetCount;
  logic        schedulerError;
  logic        busy;

  modport master (
    input  collectData, dataAvailable, bufferError, fx3Ready,
    output readData, dataValid, endOfPacket, packetCount, schedulerError, busy
  );

  modport slave (
    output collectData, dataAvailable, bufferError, fx3Ready,
    input  readData, dataValid, endOfPacket, packetCount, schedulerError, busy
  );
endinterface

// File: rtl/fx3_packet_scheduler.sv
// Read-side sequencer for the ADC sample FIFO: issues one packet of read strobes per FX3
// buffer and aligns dataValid/endOfPacket with the FIFO + 10-to-16 converter latency.
module fx3_packet_scheduler #(
  parameter int unsigned PACKET_WORDS = 8192,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input logic                   fx3Clk,
  input logic                   nReset,
  fx3_packet_scheduler_if.master bus_io
);

  localparam int unsigned CntW = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;
  localparam int unsigned TmrW = 4;
  localparam logic [CntW-1:0] LastWord  = CntW'(PACKET_WORDS - 1);
  localparam logic [TmrW-1:0] DrainLast = TmrW'(READ_LATENCY - 1);
  localparam logic [TmrW-1:0] GapLast   = TmrW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StArm, StBurst, StDrain, StGap, StHalt} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         word_cnt_q, word_cnt_d;
  logic [TmrW-1:0]         tmr_q, tmr_d;
  logic                    halt_pending_q, halt_pending_d;
  logic                    collect_q;
  logic                    busy_q, busy_d;
  logic [15:0]             packet_count_q, packet_count_d;
  logic [READ_LATENCY-1:0] valid_pipe_q, valid_pipe_d;
  logic [READ_LATENCY-1:0] eop_pipe_q, eop_pipe_d;
  logic                    read_data;
  logic                    last_word;
  logic                    eop_out;

  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    tmr_d          = tmr_q;
    halt_pending_d = halt_pending_q;
    read_data      = 1'b0;
    last_word      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.bufferError && bus_io.collectData) begin
          state_d = StHalt;
        end else if (bus_io.collectData && bus_io.dataAvailable) begin
          state_d = StArm;
        end
      end
      StArm: begin
        // Error beats fx3Ready when both arrive together.
        if (!bus_io.collectData) begin
          state_d = StIdle;
        end else if (bus_io.bufferError) begin
          state_d = StHalt;
        end else if (bus_io.fx3Ready) begin
          state_d    = StBurst;
          word_cnt_d = '0;
        end
      end
      StBurst: begin
        read_data = 1'b1;
        last_word = (word_cnt_q == LastWord);
        if (bus_io.bufferError) begin
          halt_pending_d = 1'b1;
        end
        if (last_word) begin
          state_d = StDrain;
          tmr_d   = '0;
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (tmr_q == DrainLast) begin
          tmr_d   = '0;
          state_d = halt_pending_q ? StHalt : StGap;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StGap: begin
        if (tmr_q == GapLast) begin
          tmr_d   = '0;
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StHalt: begin
        if (!bus_io.collectData) begin
          state_d        = StIdle;
          halt_pending_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobe and last-word flag travel through a pipeline matching the FIFO + converter.
  always_comb begin
    valid_pipe_d    = valid_pipe_q;
    eop_pipe_d      = eop_pipe_q;
    valid_pipe_d[0] = read_data;
    eop_pipe_d[0]   = last_word;
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      valid_pipe_d[i] = valid_pipe_q[i-1];
      eop_pipe_d[i]   = eop_pipe_q[i-1];
    end
  end

  assign eop_out = eop_pipe_q[READ_LATENCY-1];

  always_comb begin
    packet_count_d = packet_count_q;
    if (state_q == StIdle && bus_io.collectData && !collect_q) begin
      packet_count_d = '0;
    end else if (eop_out) begin
      packet_count_d = packet_count_q + 16'd1;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge fx3Clk or negedge nReset) begin
    if (!nReset) begin
      state_q        <= StIdle;
      word_cnt_q     <= '0;
      tmr_q          <= '0;
      halt_pending_q <= 1'b0;
      collect_q      <= 1'b0;
      busy_q         <= 1'b0;
      packet_count_q <= '0;
      valid_pipe_q   <= '0;
      eop_pipe_q     <= '0;
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      tmr_q          <= tmr_d;
      halt_pending_q <= halt_pending_d;
      collect_q      <= bus_io.collectData;
      busy_q         <= busy_d;
      packet_count_q <= packet_count_d;
      valid_pipe_q   <= valid_pipe_d;
      eop_pipe_q     <= eop_pipe_d;
    end
  end

  assign bus_io.readData       = read_data;
  assign bus_io.dataValid      = valid_pipe_q[READ_LATENCY-1];
  assign bus_io.endOfPacket    = eop_out;
  assign bus_io.packetCount    = packet_count_q;
  assign bus_io.schedulerError = (state_q == StHalt);
  assign bus_io.busy           = busy_q;

endmodule
